// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, image-select encodings and draw FSM states.
//   SCREEN_W / SCREEN_H : frame size in pixels / lines
//   NPIX                : pixels per frame
//   MEM_*               : memorySel encodings of the image ROMs
//   state_t             : draw-control FSM states
package game_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int NPIX     = SCREEN_W * SCREEN_H;
    localparam logic [6:0] MEM_TITLE1  = 7'd0;
    localparam logic [6:0] MEM_TITLE2  = 7'd1;
    localparam logic [6:0] MEM_CHOOSE1 = 7'd2;
    localparam logic [6:0] MEM_CHOOSE2 = 7'd3;
    localparam logic [6:0] MEM_P1WIN1  = 7'd4;
    localparam logic [6:0] MEM_P1WIN2  = 7'd5;
    typedef enum logic [1:0] {IDLE, INIT, SWEEP, DONE} state_t;
endpackage

// File: rtl/draw_sweep_counter.sv
// draw_sweep_counter: sweep timebase t plus pixel column/row trackers xi/yi.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : zero t, xi, yi
//   run          : advance t; step xi/yi on pixel-active cycles
//   addr_active  : t < W*H, the address side still has addresses to issue
//   pix_active   : t >= PIPE_DEPTH, colour data is valid this cycle
//   line_end     : xi is on the last column
//   last_pix     : xi/yi is on the final pixel of the frame
module draw_sweep_counter
    import game_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic addr_active,
    output logic pix_active,
    output logic line_end,
    output logic last_pix
);
    logic [14:0] t;
    logic [7:0]  xi;
    logic [6:0]  yi;

    assign addr_active = t < 15'(NPIX);
    assign pix_active  = t >= 15'(PIPE_DEPTH);
    assign line_end    = xi == 8'(SCREEN_W - 1);
    assign last_pix    = line_end && (yi == 7'(SCREEN_H - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            t  <= '0;
            xi <= '0;
            yi <= '0;
        end else if (run) begin
            t <= t + 15'd1;
            // the final pixel leaves xi/yi parked so they never wrap
            if (pix_active && !last_pix) begin
                xi <= line_end ? 8'd0 : xi + 8'd1;
                yi <= line_end ? yi + 7'd1 : yi;
            end
        end
    end
endmodule

// File: rtl/screen_draw_ctrl.sv
// screen_draw_ctrl: sweeps one 160x120 frame into the VGA datapath (image or black clear).
//   clk, reset                : clock, synchronous active-high reset
//   drawReq, drawSel          : start an image sweep; image select latched at accept
//   clearReq                  : start a black sweep (wins over drawReq)
//   busy, done                : sweep in progress / one-cycle completion pulse
//   plot                      : VGA write enable, aligned to the colour pipeline
//   memorySel, black          : image select and clear flag held for the sweep
//   addressScreenCounterReset, screenCountLoad : screen-address counter controls
//   xReset, yReset, xLoad, yLoad, xCountUp, yCountUp : x/y counter controls
module screen_draw_ctrl
    import game_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drawReq,
    input  logic [6:0] drawSel,
    input  logic       clearReq,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [6:0] memorySel,
    output logic       black,
    output logic       addressScreenCounterReset,
    output logic       screenCountLoad,
    output logic       xReset,
    output logic       yReset,
    output logic       xLoad,
    output logic       yLoad,
    output logic       xCountUp,
    output logic       yCountUp
);
    state_t state, next;
    logic   accept, addr_active, pix_active, line_end, last_pix;

    assign accept = (state == IDLE) && (clearReq || drawReq) && !reset;

    draw_sweep_counter #(.PIPE_DEPTH(PIPE_DEPTH)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == INIT),
        .run        (state == SWEEP),
        .addr_active(addr_active),
        .pix_active (pix_active),
        .line_end   (line_end),
        .last_pix   (last_pix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            memorySel <= '0;
            black     <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                black     <= clearReq;
                memorySel <= clearReq ? 7'd0 : drawSel;
            end else if (state == DONE) begin
                black <= 1'b0;
            end
        end
    end

    always_comb begin
        next                      = state;
        busy                      = 1'b0;
        done                      = 1'b0;
        plot                      = 1'b0;
        addressScreenCounterReset = 1'b0;
        screenCountLoad           = 1'b0;
        xReset                    = 1'b0;
        yReset                    = 1'b0;
        xLoad                     = 1'b0;
        yLoad                     = 1'b0;
        xCountUp                  = 1'b0;
        yCountUp                  = 1'b0;
        case (state)
            IDLE: begin
                busy = accept;
                next = accept ? INIT : IDLE;
            end
            INIT: begin
                busy                      = 1'b1;
                xReset                    = 1'b1;
                yReset                    = 1'b1;
                addressScreenCounterReset = 1'b1;
                next                      = SWEEP;
            end
            SWEEP: begin
                busy            = 1'b1;
                screenCountLoad = addr_active;
                plot            = pix_active;
                if (pix_active) begin
                    xLoad    = !line_end;
                    xCountUp = !line_end;
                    xReset   = line_end;
                    // the final pixel must not step y past the last line
                    yLoad    = line_end && !last_pix;
                    yCountUp = line_end && !last_pix;
                    next     = last_pix ? DONE : SWEEP;
                end
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_screen_draw_ctrl.sv
// tb_screen_draw_ctrl: directed bench for screen_draw_ctrl with datapath counter and colour-pipe model.
module tb_screen_draw_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drawReq = 1'b0, clearReq = 1'b0;
    logic [6:0] drawSel = 7'd0;
    logic       drawReq0 = 1'b0;
    logic       busy, done, plot, black, ascr, scl, xr, yr, xl, yl, xu, yu;
    logic [6:0] msel;
    logic       busy0, done0, plot0, black0, ascr0, scl0, xr0, yr0, xl0, yl0, xu0, yu0;
    logic [6:0] msel0;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int mx = 0, my = 0, sa = 0, sa_d1 = 0, sa_d2 = 0;
    int plots, dup, align, sc, done_cnt, done_cyc, first_plot, black_gap, nx, ny;
    int plots0 = 0, pmis0 = 0, done0_cyc = -1;
    bit want_next, clr_mode;
    logic [2:0] le;
    bit hit [0:119][0:159];

    always #5 clk = ~clk;

    screen_draw_ctrl dut (
        .clk(clk), .reset(reset), .drawReq(drawReq), .drawSel(drawSel), .clearReq(clearReq),
        .busy(busy), .done(done), .plot(plot), .memorySel(msel), .black(black),
        .addressScreenCounterReset(ascr), .screenCountLoad(scl),
        .xReset(xr), .yReset(yr), .xLoad(xl), .yLoad(yl), .xCountUp(xu), .yCountUp(yu)
    );

    screen_draw_ctrl #(.PIPE_DEPTH(0)) dut0 (
        .clk(clk), .reset(reset), .drawReq(drawReq0), .drawSel(7'd2), .clearReq(1'b0),
        .busy(busy0), .done(done0), .plot(plot0), .memorySel(msel0), .black(black0),
        .addressScreenCounterReset(ascr0), .screenCountLoad(scl0),
        .xReset(xr0), .yReset(yr0), .xLoad(xl0), .yLoad(yl0), .xCountUp(xu0), .yCountUp(yu0)
    );

    wire [18:0] outs  = {busy, done, plot, msel, black, ascr, scl, xr, yr, xl, yl, xu, yu};
    wire [18:0] outs0 = {busy0, done0, plot0, msel0, black0, ascr0, scl0, xr0, yr0, xl0, yl0, xu0, yu0};

    // Model: x/y counters, screen-address counter and a 2-deep colour pipe.
    // Checks use this cycle's model values, then the model takes this cycle's controls.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (plot) begin
            plots = plots + 1;
            if (first_plot < 0) first_plot = cyc;
            if (mx < 0 || mx > 159 || my < 0 || my > 119 || hit[my][mx]) dup = dup + 1;
            else hit[my][mx] = 1'b1;
            if (sa_d2 != my * 160 + mx) align = align + 1;
            if (clr_mode && !black) black_gap = black_gap + 1;
            if (want_next) begin
                nx = mx;
                ny = my;
                want_next = 1'b0;
            end
            if (mx == 159 && my == 5) begin
                le = {xr, yu, xu};
                want_next = 1'b1;
            end
        end
        if (scl) sc = sc + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        sa_d2 = sa_d1;
        sa_d1 = sa;
        sa = ascr ? 0 : scl ? sa + 1 : sa;
        mx = xr ? 0 : (xl && xu) ? mx + 1 : mx;
        my = yr ? 0 : (yl && yu) ? my + 1 : my;
        if (plot0 !== scl0) pmis0 = pmis0 + 1;
        if (plot0) plots0 = plots0 + 1;
        if (done0) done0_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats(input bit cm);
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++) hit[r][c] = 1'b0;
        plots = 0; dup = 0; align = 0; sc = 0; done_cnt = 0; done_cyc = -1;
        first_plot = -1; black_gap = 0; nx = -1; ny = -1; want_next = 1'b0;
        le = 3'b000; clr_mode = cm;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 20000) begin
            step();
            n++;
        end
        chk(tag, done_cnt, 1);
    endtask

    initial begin
        int acc;
        clear_stats(1'b0);
        repeat (3) step();
        chk("reset_outs", outs, 0);
        chk("reset_outs_p0", outs0, 0);
        chk("reset_state", dut.state, IDLE);
        reset = 1'b0;
        step();

        // image sweep, with the PIPE_DEPTH=0 build started in the same cycle
        clear_stats(1'b0);
        drawReq = 1'b1; drawSel = 7'd3; drawReq0 = 1'b1;
        acc = cyc;
        #1;
        chk("busy_accept", busy, 1);
        step();
        drawReq = 1'b0; drawReq0 = 1'b0; drawSel = 7'd0;
        chk("msel_draw", msel, 3);
        wait_done("done_draw");
        repeat (3) step();
        chk("first_plot_lat", first_plot - acc, 4);
        chk("done_lat", done_cyc - acc, 19204);
        chk("plots_draw", plots, 19200);
        chk("dup_draw", dup, 0);
        chk("align_draw", align, 0);
        chk("addr_adv_draw", sc, 19200);
        chk("line_end_ctl", le, 3'b110);
        chk("after_line_xy", {nx[15:0], ny[15:0]}, {16'd0, 16'd6});
        chk("done_pulses", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("state_after", dut.state, IDLE);
        chk("p0_done_lat", done0_cyc - acc, 19202);
        chk("p0_plot_eq_scl", pmis0, 0);
        chk("p0_plots", plots0, 19200);

        // clear beats draw; a mid-sweep draw request is ignored
        clear_stats(1'b1);
        clearReq = 1'b1; drawReq = 1'b1; drawSel = 7'd5;
        step();
        clearReq = 1'b0; drawReq = 1'b0;
        repeat (1000) step();
        chk("black_mid", black, 1);
        drawReq = 1'b1; drawSel = 7'd9;
        step();
        drawReq = 1'b0;
        repeat (5) step();
        chk("msel_ignored", msel, 0);
        chk("busy_mid", busy, 1);
        wait_done("done_clear");
        repeat (3) step();
        chk("plots_clear", plots, 19200);
        chk("dup_clear", dup, 0);
        chk("black_gap", black_gap, 0);
        chk("done_clear_cnt", done_cnt, 1);
        chk("busy_clear_after", busy, 0);

        // reset part-way through a sweep
        clear_stats(1'b0);
        drawReq = 1'b1; drawSel = 7'd1;
        acc = cyc;
        step();
        drawReq = 1'b0;
        repeat (5001) step();
        chk("busy_pre_reset", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_mid_outs", outs, 0);
        chk("reset_mid_state", dut.state, IDLE);
        repeat (10) step();
        chk("reset_mid_no_done", done_cnt, 0);

        clear_stats(1'b0);
        drawReq = 1'b1; drawSel = 7'd4;
        step();
        drawReq = 1'b0;
        wait_done("done_resweep");
        repeat (3) step();
        chk("plots_resweep", plots, 19200);
        chk("dup_resweep", dup, 0);
        chk("align_resweep", align, 0);
        chk("msel_resweep", msel, 4);
        chk("done_resweep_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
